// File: rtl/tagged_div_dispatcher_pkg.sv
// Shared types for the normalize-stage front end.
// TAG_SIZE may be overridden on the command line; it defaults to 64.
`ifndef TAG_SIZE
`define TAG_SIZE 64
`endif

package tagged_div_dispatcher_pkg;

    localparam int TAG_SIZE = `TAG_SIZE;
    localparam int CNT_W    = $clog2(TAG_SIZE) + 1;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } RayDirection;

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        RayDirection         dir;
    } TaggedRay;

    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        RayDirection         dir;
    } TaggedNormalized;

    // Rotate a one-hot tag left by one, wrapping the MSB back to bit 0.
    function automatic logic [TAG_SIZE-1:0] next_onehot(input logic [TAG_SIZE-1:0] t);
        logic [TAG_SIZE-1:0] r;
        if (t[TAG_SIZE-1]) begin
            r = {{(TAG_SIZE-1){1'b0}}, 1'b1};
        end else begin
            r = t << 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tagged_div_dispatcher_tag_gen.sv
// onehot_tag_gen: rotating one-hot tag source. Starts at 1 after reset so the
// first tag matches the reorder buffer's first expected tag.
module onehot_tag_gen
    import tagged_div_dispatcher_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    output logic [TAG_SIZE-1:0] tag_out
);

    // Step to the next one-hot tag whenever a ray takes the current one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_out <= {{(TAG_SIZE-1){1'b0}}, 1'b1};
        end else if (advance) begin
            tag_out <= next_onehot(tag_out);
        end
    end

endmodule

// File: rtl/tagged_div_dispatcher.sv
// tagged_div_dispatcher: stamps incoming rays with a rotating one-hot tag and
// hands them round-robin to the divider lanes, never letting more than
// TAG_SIZE rays be in flight so a tag cannot be reused before it retires.
// Optional feature macro: DISPATCH_STATS_EN adds dispatch/stall counters.
module tagged_div_dispatcher
    import tagged_div_dispatcher_pkg::*;
#(
    parameter int DIV_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ray_valid_in,
    input  RayDirection          ray_in,
    output logic                 ray_ready_out,
    input  logic [DIV_COUNT-1:0] div_ready_in,
    input  logic [DIV_COUNT-1:0] div_overflow_in,
    input  logic                 retire_in,
    output logic [DIV_COUNT-1:0] div_valid_out,
    output TaggedRay             div_data_out,
    output logic [CNT_W-1:0]     outstanding_out
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]          dispatched_cnt_out,
    output logic [31:0]          stall_cnt_out
`endif
);

    localparam int LANE_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

    logic                 stage_valid;
    RayDirection          stage_ray;
    logic [TAG_SIZE-1:0]  stage_tag;
    logic [TAG_SIZE-1:0]  cur_tag;
    logic [LANE_W-1:0]    rr_ptr;
    logic [DIV_COUNT-1:0] elig;
    logic [LANE_W-1:0]    sel;
    logic                 sel_found;
    logic                 fire;
    logic                 accept;

    assign elig          = div_ready_in & ~div_overflow_in;
    assign fire          = stage_valid && sel_found && (outstanding_out < CNT_W'(TAG_SIZE));
    assign ray_ready_out = !stage_valid || fire;
    assign accept        = ray_valid_in && ray_ready_out;

    onehot_tag_gen u_tag_gen (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .tag_out (cur_tag)
    );

    // Pick the first eligible lane at or above rr_ptr, wrapping around.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < DIV_COUNT; k++) begin
            int cand;
            cand = int'(rr_ptr) + k;
            if (cand >= DIV_COUNT) begin
                cand = cand - DIV_COUNT;
            end
            if (!sel_found && elig[LANE_W'(cand)]) begin
                sel_found = 1'b1;
                sel       = LANE_W'(cand);
            end
        end
    end

    // Holding stage: load on accept, empty when its ray fires without a refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_ray   <= '0;
            stage_tag   <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_ray   <= ray_in;
            stage_tag   <= cur_tag;
        end else if (fire) begin
            stage_valid <= 1'b0;
        end
    end

    // Registered dispatch strobe/payload and round-robin pointer advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_valid_out <= '0;
            div_data_out  <= '0;
            rr_ptr        <= '0;
        end else if (fire) begin
            div_valid_out <= DIV_COUNT'(1) << sel;
            div_data_out  <= {stage_tag, stage_ray};
            rr_ptr        <= (sel == LANE_W'(DIV_COUNT - 1)) ? '0 : sel + 1'b1;
        end else begin
            div_valid_out <= '0;
        end
    end

    // In-flight count: up on dispatch, down on retire, floor at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_out <= '0;
        end else if (fire && !retire_in) begin
            outstanding_out <= outstanding_out + 1'b1;
        end else if (!fire && retire_in && (outstanding_out != '0)) begin
            outstanding_out <= outstanding_out - 1'b1;
        end
    end

`ifdef DISPATCH_STATS_EN
    // Free-running statistics: rays dispatched and cycles a staged ray waited.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dispatched_cnt_out <= '0;
            stall_cnt_out      <= '0;
        end else begin
            if (fire) begin
                dispatched_cnt_out <= dispatched_cnt_out + 32'd1;
            end
            if (stage_valid && !fire) begin
                stall_cnt_out <= stall_cnt_out + 32'd1;
            end
        end
    end
`endif

endmodule
